// File: rtl/intersection_controller_if.sv
// Signal bundle between the intersection controller and its surroundings.
// master: the side that supplies the time base and sensors and consumes the lights.
// slave:  the intersection controller itself.
// Optional feature macro: PED_WALK_EN adds ped_btn and walk.
interface intersection_controller_if;
  logic       tick;
  logic       ew_car;
  logic       ns_g;
  logic       ns_y;
  logic       ns_r;
  logic       ew_g;
  logic       ew_y;
  logic       ew_r;
  logic [2:0] state;
`ifdef PED_WALK_EN
  logic       ped_btn;
  logic       walk;

  modport master (
    output tick, ew_car, ped_btn,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, state, walk
  );

  modport slave (
    input  tick, ew_car, ped_btn,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, state, walk
  );
`else
  modport master (
    output tick, ew_car,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, state
  );

  modport slave (
    input  tick, ew_car,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, state
  );
`endif
endinterface

// File: rtl/intersection_controller.sv
// Major/minor intersection sequencer. NS rests in green and EW is served only
// when a latched car request is pending. A Moore FSM with a tick-driven dwell
// timer steps NSG -> NSY -> AR1 -> EWG -> EWY -> AR2 -> NSG. Light outputs are
// registered from the next state so they change on the same edge as the state.
// Optional feature macro: PED_WALK_EN adds a pedestrian request (ped_btn) that
// also calls the EW phase, and a walk output that is high during EWG.
module intersection_controller #(
  parameter int NS_GREEN_T = 8,
  parameter int EW_GREEN_T = 6,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 1,
  parameter int TW         = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  intersection_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    NSG = 3'd0,
    NSY = 3'd1,
    AR1 = 3'd2,
    EWG = 3'd3,
    EWY = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [TW-1:0] NSG_LOAD = TW'(NS_GREEN_T - 1);
  localparam logic [TW-1:0] EWG_LOAD = TW'(EW_GREEN_T - 1);
  localparam logic [TW-1:0] YEL_LOAD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LOAD  = TW'(ALLRED_T - 1);

  state_t        state_q;
  state_t        next_state;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] next_timer;
  logic          ew_req_q;
  logic          next_ew_req;
  logic          expired;
  logic          enter_ewg;
  logic          service_req;

  logic ns_g_q, ns_y_q, ns_r_q, ew_g_q, ew_y_q, ew_r_q;
  logic next_ns_g, next_ns_y, next_ns_r, next_ew_g, next_ew_y, next_ew_r;

`ifdef PED_WALK_EN
  logic ped_req_q;
  logic next_ped_req;
  logic walk_q;
  logic next_walk;
`endif

  // Timer reload value for the state being entered.
  function automatic logic [TW-1:0] dwell_load(input state_t s);
    logic [TW-1:0] load;
    case (s)
      NSG:      load = NSG_LOAD;
      NSY, EWY: load = YEL_LOAD;
      EWG:      load = EWG_LOAD;
      default:  load = AR_LOAD;
    endcase
    return load;
  endfunction

  // Next state, timer and request latches; a request seen on the EWG entry edge is dropped.
  always_comb begin
    next_state  = state_q;
    next_timer  = timer_q;
    expired     = bus.tick && (timer_q == '0);
`ifdef PED_WALK_EN
    service_req = ew_req_q | ped_req_q;
`else
    service_req = ew_req_q;
`endif
    case (state_q)
      NSG:     if (expired && service_req) next_state = NSY;
      NSY:     if (expired) next_state = AR1;
      AR1:     if (expired) next_state = EWG;
      EWG:     if (expired) next_state = EWY;
      EWY:     if (expired) next_state = AR2;
      AR2:     if (expired) next_state = NSG;
      default: next_state = AR2;
    endcase
    if (next_state != state_q) begin
      next_timer = dwell_load(next_state);
    end else if (bus.tick && (timer_q != '0)) begin
      next_timer = timer_q - TW'(1);
    end
    enter_ewg   = (next_state == EWG) && (state_q != EWG);
    next_ew_req = (ew_req_q | bus.ew_car) & ~enter_ewg;
`ifdef PED_WALK_EN
    next_ped_req = (ped_req_q | bus.ped_btn) & ~enter_ewg;
`endif
  end

  // Light decode from the next state so the registered lights track the state register.
  always_comb begin
    next_ns_g = (next_state == NSG);
    next_ns_y = (next_state == NSY);
    next_ns_r = !(next_ns_g || next_ns_y);
    next_ew_g = (next_state == EWG);
    next_ew_y = (next_state == EWY);
    next_ew_r = !(next_ew_g || next_ew_y);
`ifdef PED_WALK_EN
    next_walk = (next_state == EWG);
`endif
  end

  // State, dwell timer and request latches; reset discards any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NSG;
      timer_q   <= NSG_LOAD;
      ew_req_q  <= 1'b0;
`ifdef PED_WALK_EN
      ped_req_q <= 1'b0;
`endif
    end else begin
      state_q   <= next_state;
      timer_q   <= next_timer;
      ew_req_q  <= next_ew_req;
`ifdef PED_WALK_EN
      ped_req_q <= next_ped_req;
`endif
    end
  end

  // Registered light outputs; reset shows NS green against EW red.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_g_q <= 1'b1;
      ns_y_q <= 1'b0;
      ns_r_q <= 1'b0;
      ew_g_q <= 1'b0;
      ew_y_q <= 1'b0;
      ew_r_q <= 1'b1;
`ifdef PED_WALK_EN
      walk_q <= 1'b0;
`endif
    end else begin
      ns_g_q <= next_ns_g;
      ns_y_q <= next_ns_y;
      ns_r_q <= next_ns_r;
      ew_g_q <= next_ew_g;
      ew_y_q <= next_ew_y;
      ew_r_q <= next_ew_r;
`ifdef PED_WALK_EN
      walk_q <= next_walk;
`endif
    end
  end

  assign bus.ns_g  = ns_g_q;
  assign bus.ns_y  = ns_y_q;
  assign bus.ns_r  = ns_r_q;
  assign bus.ew_g  = ew_g_q;
  assign bus.ew_y  = ew_y_q;
  assign bus.ew_r  = ew_r_q;
  assign bus.state = state_q;
`ifdef PED_WALK_EN
  assign bus.walk  = walk_q;
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// Testbench for intersection_controller. The driver issues one input set per
// clock, advances a phase/tick-count reference model and queues the expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_intersection_controller;

  localparam int NS_T = 8;
  localparam int EW_T = 6;
  localparam int Y_T  = 2;
  localparam int AR_T = 1;
`ifdef PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  intersection_controller_if bus();

  intersection_controller #(
    .NS_GREEN_T(NS_T),
    .EW_GREEN_T(EW_T),
    .YELLOW_T  (Y_T),
    .ALLRED_T  (AR_T),
    .TW        (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_q[$];
  logic [9:0] act_vec;
  logic       walk_act;

  // Phase durations in ticks, indexed NSG, NSY, AR1, EWG, EWY, AR2.
  int dwell[6] = '{NS_T, Y_T, AR_T, EW_T, Y_T, AR_T};
  int m_phase  = 0;
  int m_ticks  = 0;
  bit m_ew_req = 1'b0;
  bit m_ped_req = 1'b0;

`ifdef PED_WALK_EN
  assign walk_act = bus.walk;
`else
  assign walk_act = 1'b0;
`endif

  assign act_vec = {bus.state, bus.ns_g, bus.ns_y, bus.ns_r,
                    bus.ew_g, bus.ew_y, bus.ew_r, walk_act};

  // Expected output vector for the model's current phase.
  function automatic logic [9:0] model_vec();
    logic [2:0] code;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;
    code = 3'(m_phase);
    ns_g = (m_phase == 0);
    ns_y = (m_phase == 1);
    ns_r = (m_phase >= 2);
    ew_g = (m_phase == 3);
    ew_y = (m_phase == 4);
    ew_r = (m_phase != 3) && (m_phase != 4);
    walk = PED_EN && (m_phase == 3);
    return {code, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};
  endfunction

  function automatic void model_reset();
    m_phase   = 0;
    m_ticks   = 0;
    m_ew_req  = 1'b0;
    m_ped_req = 1'b0;
  endfunction

  // One clock edge of the reference model: a phase ends on the tick that
  // completes its dwell; NS green also needs a pending request to leave.
  function automatic void model_step(input bit t, input bit car, input bit ped);
    int  nxt;
    bit  enter_ewg;
    bit  done;
    nxt  = m_phase;
    done = 1'b0;
    if (t) begin
      if (m_ticks < dwell[m_phase]) m_ticks++;
      done = (m_ticks == dwell[m_phase]);
    end
    if (done && (m_phase != 0 || m_ew_req || m_ped_req)) nxt = (m_phase + 1) % 6;
    enter_ewg = (nxt == 3) && (m_phase != 3);
    m_ew_req  = (m_ew_req | car) & !enter_ewg;
    m_ped_req = PED_EN & (m_ped_req | ped) & !enter_ewg;
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_ticks = 0;
    end
  endfunction

  task automatic checkOutput(input logic [9:0] expv, input logic [9:0] actv, input string name);
    checks++;
    if (actv !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actv, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the next rising edge.
  task automatic applyStimulus(input bit t, input bit car, input bit ped);
    @(negedge clk);
    #1;
    rst_n      = 1'b1;
    bus.tick   = t;
    bus.ew_car = car;
`ifdef PED_WALK_EN
    bus.ped_btn = ped;
`endif
    model_step(t, car, ped);
    exp_q.push_back(model_vec());
  endtask

  // Assert reset mid-cycle and confirm the lights respond before any clock edge.
  task automatic pulseReset();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    bus.ew_car = 1'b1;
    #1;
    model_reset();
    checkOutput(model_vec(), act_vec, "async_reset");
    exp_q.push_back(model_vec());
  endtask

  // Monitor: compare each queued expectation and the safety rule every cycle.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e, act_vec, "lights_state");
        checks++;
        if ((bus.ns_g | bus.ns_y) && (bus.ew_g | bus.ew_y)) begin
          failures++;
          $display("[TB] FAIL safety: ns_g=%b ns_y=%b ew_g=%b ew_y=%b required no overlap at %0t",
                   bus.ns_g, bus.ns_y, bus.ew_g, bus.ew_y, $time);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int n;
    rst_n      = 1'b0;
    bus.tick   = 1'b1;
    bus.ew_car = 1'b0;
`ifdef PED_WALK_EN
    bus.ped_btn = 1'b0;
`endif
    model_reset();
    #12;
    checkOutput(model_vec(), act_vec, "reset_state");

    $display("[TB] NSG rests with no requests");
    for (int i = 0; i < 55; i++) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] single car pulse");
    pulseReset();
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, (i == 2), 1'b0);

    $display("[TB] car held high, continuous cycling");
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1, 1'b0);

    $display("[TB] tick every 4th clock");
    for (int i = 0; i < 200; i++) applyStimulus((i % 4) == 3, 1'b1, 1'b0);

    $display("[TB] reset during EWG");
    n = 0;
    while (m_phase != 3 && n < 100) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    pulseReset();
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 1'b0);

    if (PED_EN) begin
      $display("[TB] pedestrian request only");
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, (i == 1));
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 19) == 0);
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
